// File: rtl/pwm_plane_mem_if.sv
// Duty-word write port of the PWM bit-plane store: valid/ready handshake with channel index and duty word.
// The producer drives the master side and the plane store is the slave.
interface pwm_plane_mem_if #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 4
);
    localparam int CW = (num_pwm > 1) ? $clog2(num_pwm) : 1;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [CW-1:0]        wr_chan;
    logic [pwm_width-1:0] wr_duty;

    modport master (
        output wr_valid,
        output wr_chan,
        output wr_duty,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_chan,
        input  wr_duty,
        output wr_ready
    );
endinterface

// File: rtl/pwm_plane_mem.sv
// Bit-plane store for the bit-plane PWM engine: duty words are transposed into a shadow plane
// buffer and copied to the active buffer on latch_mem. Optional frame commit: `define PWM_MEM_COMMIT_EN.
//   state   | meaning
//   OPEN    | shadow writable, latch_mem ignored (active holds)
//   PENDING | frame committed, shadow frozen until the next latch_mem swap
module pwm_plane_mem #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 4,
    localparam int AW = (pwm_width > 1) ? $clog2(pwm_width) : 1
) (
    input  logic               clk,
    input  logic               rst,
    pwm_plane_mem_if.slave     wr_if,
    input  logic [AW-1:0]      pwm_addr_i,
    output logic [num_pwm-1:0] pwm_data_o,
    input  logic               latch_mem_i,
`ifdef PWM_MEM_COMMIT_EN
    input  logic               commit_i,
`endif
    output logic               swap_done_o
);
    localparam int CW = (num_pwm > 1) ? $clog2(num_pwm) : 1;

    typedef logic [num_pwm-1:0] plane_t;

    plane_t shadow_q [pwm_width];
    plane_t shadow_d [pwm_width];
    plane_t active_q [pwm_width];
    plane_t active_d [pwm_width];

    logic wr_ready_q;
    logic swap_done_q;
    logic wr_fire;
    logic swap_en;

    assign wr_fire = wr_if.wr_valid & wr_ready_q;

`ifdef PWM_MEM_COMMIT_EN
    typedef enum logic [0:0] {
        ST_OPEN    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t state_q;

    assign swap_en = latch_mem_i & (state_q == ST_PENDING);

    // A write accepted on the commit edge still lands; the ready drop only blocks later writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OPEN;
            wr_ready_q  <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            swap_done_q <= swap_en;
            case (state_q)
                ST_OPEN: begin
                    wr_ready_q <= ~commit_i;
                    if (commit_i) begin
                        state_q <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    wr_ready_q <= latch_mem_i;
                    if (latch_mem_i) begin
                        state_q <= ST_OPEN;
                    end
                end
                default: begin
                    state_q    <= ST_OPEN;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    assign swap_en = latch_mem_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready_q  <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            wr_ready_q  <= 1'b1;
            swap_done_q <= swap_en;
        end
    end
`endif

    // Swap copies the pre-edge shadow, so a write on the same edge waits for the next swap.
    // Out-of-range channel indices match no column and are silently dropped.
    always_comb begin
        for (int i = 0; i < pwm_width; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = swap_en ? shadow_q[i] : active_q[i];
            for (int c = 0; c < num_pwm; c++) begin
                if (wr_fire && (wr_if.wr_chan == CW'(c))) begin
                    shadow_d[i][c] = wr_if.wr_duty[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < pwm_width; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < pwm_width; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // Plane addresses beyond pwm_width match nothing and read as zero.
    always_comb begin
        pwm_data_o = '0;
        for (int i = 0; i < pwm_width; i++) begin
            if (pwm_addr_i == AW'(i)) begin
                pwm_data_o = active_q[i];
            end
        end
    end

    assign wr_if.wr_ready = wr_ready_q;
    assign swap_done_o    = swap_done_q;
endmodule

// File: tb/tb_pwm_plane_mem.sv
// Self-checking bench for pwm_plane_mem: a 16x4 instance for the main scenarios and a 12x3
// instance for out-of-range channel and plane-address cases.
`timescale 1ns/1ps
module tb_pwm_plane_mem;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_plane_mem_if #(.pwm_width(16), .num_pwm(4)) wif ();
    pwm_plane_mem_if #(.pwm_width(12), .num_pwm(3)) wif3 ();

    logic [3:0] pwm_addr, pwm_addr3;
    logic [3:0] pwm_data;
    logic [2:0] pwm_data3;
    logic       latch, latch3, swap_done, swap_done3;
`ifdef PWM_MEM_COMMIT_EN
    logic       commit, commit3;
`endif

    pwm_plane_mem #(.pwm_width(16), .num_pwm(4)) dut (
        .clk(clk), .rst(rst), .wr_if(wif), .pwm_addr_i(pwm_addr), .pwm_data_o(pwm_data),
        .latch_mem_i(latch),
`ifdef PWM_MEM_COMMIT_EN
        .commit_i(commit),
`endif
        .swap_done_o(swap_done));

    pwm_plane_mem #(.pwm_width(12), .num_pwm(3)) dut3 (
        .clk(clk), .rst(rst), .wr_if(wif3), .pwm_addr_i(pwm_addr3), .pwm_data_o(pwm_data3),
        .latch_mem_i(latch3),
`ifdef PWM_MEM_COMMIT_EN
        .commit_i(commit3),
`endif
        .swap_done_o(swap_done3));

    typedef struct {
        int         addr;
        logic [3:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb3_q[$];
    int          meas_q[$];
    logic [15:0] duty_m [4];
    logic [15:0] act_m  [4];
    logic [11:0] duty3_m[3];
    logic [11:0] act3_m [3];
    int          checks = 0;
    int          failures = 0;

    // Model holds whole duty words per channel; expected planes are sliced from them.
    task automatic push_active();
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            e.addr = a;
            e.data = {act_m[3][a], act_m[2][a], act_m[1][a], act_m[0][a]};
            sb_q.push_back(e);
        end
    endtask

    task automatic push_active3();
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            e.addr = a;
            e.data = 4'b0000;
            if (a < 12) e.data = {1'b0, act3_m[2][a], act3_m[1][a], act3_m[0][a]};
            sb3_q.push_back(e);
        end
    endtask

    task automatic drain_sb(string name);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            pwm_addr = e.addr[3:0];
            #2;
            checks++;
            if (pwm_data !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d: pwm_data=%b expected %b", name, e.addr, pwm_data, e.data);
            end
            @(negedge clk);
        end
    endtask

    task automatic drain_sb3(string name);
        exp_t e;
        while (sb3_q.size() > 0) begin
            e = sb3_q.pop_front();
            pwm_addr3 = e.addr[3:0];
            #2;
            checks++;
            if ({1'b0, pwm_data3} !== e.data) begin
                failures++;
                $display("FAIL %s addr=%0d: pwm_data=%b expected %b", name, e.addr, pwm_data3, e.data[2:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_bit(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic write_word(int ch, logic [15:0] duty);
        int n = 0;
        wif.wr_valid = 1'b1;
        wif.wr_chan  = ch[1:0];
        wif.wr_duty  = duty;
        while (!wif.wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("write_handshake", wif.wr_ready, 1'b1);
        @(negedge clk);
        wif.wr_valid = 1'b0;
        duty_m[ch] = duty;
    endtask

    task automatic do_swap(string name);
        latch = 1'b1;
        act_m = duty_m;
        push_active();
        @(negedge clk);
        latch = 1'b0;
        check_bit({name, "_swap_done"}, swap_done, 1'b1);
        @(negedge clk);
        check_bit({name, "_swap_done_clr"}, swap_done, 1'b0);
        drain_sb(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        check_bit("reset_wr_ready", wif.wr_ready, 1'b0);
        check_bit("reset_swap_done", swap_done, 1'b0);
        checks++;
        if (pwm_data !== 4'b0) begin
            failures++;
            $display("FAIL reset_pwm_data: got %b expected 0000", pwm_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("reset_ready_before_edge", wif.wr_ready, 1'b0);
        @(negedge clk);
        check_bit("reset_ready_after_edge", wif.wr_ready, 1'b1);
        check_bit("reset_ready3_after_edge", wif3.wr_ready, 1'b1);
    endtask

    task automatic test_write_swap();
        write_word(1, 16'hA005);
        do_swap("write_swap");
    endtask

    task automatic test_same_cycle();
        act_m = duty_m;
        push_active();
        wif.wr_valid = 1'b1;
        wif.wr_chan  = 2'd0;
        wif.wr_duty  = 16'hFFFF;
        latch = 1'b1;
        @(negedge clk);
        wif.wr_valid = 1'b0;
        latch = 1'b0;
        duty_m[0] = 16'hFFFF;
        check_bit("same_cycle_swap_done", swap_done, 1'b1);
        @(negedge clk);
        check_bit("same_cycle_swap_done_clr", swap_done, 1'b0);
        drain_sb("same_cycle_old");
        do_swap("same_cycle_next");
        latch = 1'b1;
        repeat (3) @(negedge clk);
        latch = 1'b0;
        check_bit("held_latch_swap_done", swap_done, 1'b1);
        act_m = duty_m;
        push_active();
        @(negedge clk);
        drain_sb("held_latch");
    endtask

    task automatic swap3(string name);
        latch3 = 1'b1;
        act3_m = duty3_m;
        push_active3();
        @(negedge clk);
        latch3 = 1'b0;
        check_bit({name, "_swap_done"}, swap_done3, 1'b1);
        @(negedge clk);
        drain_sb3(name);
    endtask

    task automatic test_bad_chan();
        int n = 0;
        wif3.wr_valid = 1'b1;
        wif3.wr_chan  = 2'd1;
        wif3.wr_duty  = 12'h5A3;
        @(negedge clk);
        wif3.wr_valid = 1'b0;
        duty3_m[1] = 12'h5A3;
        swap3("chan3_base");
        wif3.wr_valid = 1'b1;
        wif3.wr_chan  = 2'd3;
        wif3.wr_duty  = 12'hFFF;
        while (!wif3.wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("bad_chan_handshake", wif3.wr_ready, 1'b1);
        @(negedge clk);
        wif3.wr_valid = 1'b0;
        check_bit("bad_chan_ready_after", wif3.wr_ready, 1'b1);
        swap3("bad_chan_dropped");
    endtask

    task automatic test_engine();
        int meas [4];
        int exp_v;
        logic [15:0] duties [4];
        duties = '{16'd0, 16'd1, 16'd32768, 16'd65535};
        for (int c = 0; c < 4; c++) begin
            write_word(c, duties[c]);
            meas_q.push_back(int'(duties[c]));
        end
        do_swap("engine_planes");
        meas = '{0, 0, 0, 0};
        for (int a = 0; a < 16; a++) begin
            pwm_addr = a[3:0];
            #2;
            for (int c = 0; c < 4; c++) meas[c] += int'(pwm_data[c]) << a;
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++) begin
            exp_v = meas_q.pop_front();
            checks++;
            if (meas[c] < exp_v - 1 || meas[c] > exp_v + 1) begin
                failures++;
                $display("FAIL engine_high_cycles ch%0d: measured %0d expected %0d", c, meas[c], exp_v);
            end
        end
    endtask

    task automatic test_midrun_reset();
        pwm_addr = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (pwm_data !== 4'b0 || pwm_data3 !== 3'b0) begin
            failures++;
            $display("FAIL midrun_reset_pwm_data: got %b/%b expected 0000/000", pwm_data, pwm_data3);
        end
        check_bit("midrun_reset_ready", wif.wr_ready, 1'b0);
        check_bit("midrun_reset_swap_done", swap_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("midrun_ready_before_edge", wif.wr_ready, 1'b0);
        @(negedge clk);
        check_bit("midrun_ready_after_edge", wif.wr_ready, 1'b1);
        duty_m = '{16'd0, 16'd0, 16'd0, 16'd0};
        do_swap("midrun_shadow_cleared");
    endtask

`ifdef PWM_MEM_COMMIT_EN
    task automatic test_commit();
        write_word(2, 16'h0001);
        latch = 1'b1;
        @(negedge clk);
        latch = 1'b0;
        check_bit("commit_open_no_swap_done", swap_done, 1'b0);
        push_active();
        drain_sb("commit_open_latch_ignored");
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check_bit("commit_ready_low", wif.wr_ready, 1'b0);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check_bit("commit_pending_ignored", wif.wr_ready, 1'b0);
        @(negedge clk);
        check_bit("commit_ready_held_low", wif.wr_ready, 1'b0);
        latch = 1'b1;
        act_m = duty_m;
        push_active();
        @(negedge clk);
        latch = 1'b0;
        check_bit("commit_swap_done", swap_done, 1'b1);
        check_bit("commit_ready_back", wif.wr_ready, 1'b1);
        drain_sb("commit_swap");
        wif.wr_valid = 1'b1;
        wif.wr_chan  = 2'd0;
        wif.wr_duty  = 16'h0003;
        commit = 1'b1;
        @(negedge clk);
        wif.wr_valid = 1'b0;
        commit = 1'b0;
        duty_m[0] = 16'h0003;
        check_bit("commit_with_write_ready", wif.wr_ready, 1'b0);
        do_swap("commit_with_write");
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        wif.wr_valid = 1'b0; wif.wr_chan = '0; wif.wr_duty = '0;
        wif3.wr_valid = 1'b0; wif3.wr_chan = '0; wif3.wr_duty = '0;
        pwm_addr = '0; pwm_addr3 = '0; latch = 1'b0; latch3 = 1'b0;
`ifdef PWM_MEM_COMMIT_EN
        commit = 1'b0; commit3 = 1'b0;
`endif
        duty_m  = '{16'd0, 16'd0, 16'd0, 16'd0};
        act_m   = duty_m;
        duty3_m = '{12'd0, 12'd0, 12'd0};
        act3_m  = duty3_m;
        test_reset();
`ifdef PWM_MEM_COMMIT_EN
        test_commit();
`else
        test_write_swap();
        test_same_cycle();
        test_bad_chan();
        test_engine();
        test_midrun_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
